// File: rtl/ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core: FSM states, opcodes
// and the datapath select / ALU-op codes consumed by the ALU decoder and datapath.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_UPPER    = 4'd8,
      S_ALUWB    = 4'd9,
      S_BRANCH   = 4'd10,
      S_JAL      = 4'd11,
      S_JALR     = 4'd12,
      S_LINK     = 4'd13,
      S_TRAP     = 4'd14
   } stateT;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } aluOpT;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'd0,
      SRCA_OLDPC = 2'd1,
      SRCA_RD1   = 2'd2,
      SRCA_ZERO  = 2'd3
   } srcAT;

   typedef enum logic [1:0] {
      SRCB_RD2  = 2'd0,
      SRCB_IMM  = 2'd1,
      SRCB_FOUR = 2'd2
   } srcBT;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'd0,
      RES_DATA      = 2'd1,
      RES_ALURESULT = 2'd2
   } resultSrcT;

   // Opcode dispatch out of DECODE; unknown opcodes trap or fall back to fetch.
   function automatic stateT decodeTarget(input logic [6:0] op, input bit trapOnIllegal);
      stateT nxt;
      case (op)
         OP_LOAD, OP_STORE: nxt = S_MEMADR;
         OP_RTYPE:          nxt = S_EXECR;
         OP_ITYPE:          nxt = S_EXECI;
         OP_BRANCH:         nxt = S_BRANCH;
         OP_JAL:            nxt = S_JAL;
         OP_JALR:           nxt = S_JALR;
         OP_LUI, OP_AUIPC:  nxt = S_UPPER;
         default:           nxt = trapOnIllegal ? S_TRAP : S_FETCH;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives datapath selects, enables and the 2-bit alu_op.
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter stateT RESET_STATE     = S_FETCH,
   parameter bit    TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] op,
   input  logic       cond,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       illegal_instr,
   output logic [3:0] state_dbg
);

   stateT     state, nextState;
   logic      illegalSticky;
   logic      memReqC, memWriteC, adrSrcC, irWriteC, pcUpdateC, branchC, regWriteC;
   resultSrcT resultSrcC;
   srcAT      srcAC;
   srcBT      srcBC;
   aluOpT     aluOpC;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= RESET_STATE;
      else         state <= nextState;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                  illegalSticky <= 1'b0;
      else if (nextState == S_TRAP) illegalSticky <= 1'b1;
   end

   always_comb begin
      nextState  = state;
      memReqC    = 1'b0;
      memWriteC  = 1'b0;
      adrSrcC    = 1'b0;
      irWriteC   = 1'b0;
      pcUpdateC  = 1'b0;
      branchC    = 1'b0;
      regWriteC  = 1'b0;
      resultSrcC = RES_ALUOUT;
      srcAC      = SRCA_PC;
      srcBC      = SRCB_RD2;
      aluOpC     = ALU_ADD;
      case (state)
         S_FETCH: begin
            memReqC    = 1'b1;
            srcBC      = SRCB_FOUR;
            resultSrcC = RES_ALURESULT;
            if (mem_ready) begin
               irWriteC  = 1'b1;
               pcUpdateC = 1'b1;
               nextState = S_DECODE;
            end
         end
         S_DECODE: begin
            srcAC     = SRCA_OLDPC;
            srcBC     = SRCB_IMM;
            nextState = decodeTarget(op, TRAP_ON_ILLEGAL);
         end
         S_MEMADR: begin
            srcAC     = SRCA_RD1;
            srcBC     = SRCB_IMM;
            nextState = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            memReqC = 1'b1;
            adrSrcC = 1'b1;
            if (mem_ready) nextState = S_MEMWB;
         end
         S_MEMWB: begin
            resultSrcC = RES_DATA;
            regWriteC  = 1'b1;
            nextState  = S_FETCH;
         end
         S_MEMWRITE: begin
            memReqC   = 1'b1;
            memWriteC = 1'b1;
            adrSrcC   = 1'b1;
            if (mem_ready) nextState = S_FETCH;
         end
         S_EXECR: begin
            srcAC     = SRCA_RD1;
            srcBC     = SRCB_RD2;
            aluOpC    = ALU_FUNCT;
            nextState = S_ALUWB;
         end
         S_EXECI: begin
            srcAC     = SRCA_RD1;
            srcBC     = SRCB_IMM;
            aluOpC    = ALU_FUNCT;
            nextState = S_ALUWB;
         end
         S_UPPER: begin
            srcAC     = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            srcBC     = SRCB_IMM;
            nextState = S_ALUWB;
         end
         S_ALUWB: begin
            regWriteC = 1'b1;
            nextState = S_FETCH;
         end
         S_BRANCH: begin
            srcAC     = SRCA_RD1;
            srcBC     = SRCB_RD2;
            aluOpC    = ALU_SUB;
            branchC   = 1'b1;
            nextState = S_FETCH;
         end
         // Target computed in DECODE sits in ALUOut; ALU now forms the link value.
         S_JAL: begin
            srcAC     = SRCA_OLDPC;
            srcBC     = SRCB_FOUR;
            pcUpdateC = 1'b1;
            nextState = S_ALUWB;
         end
         S_JALR: begin
            srcAC      = SRCA_RD1;
            srcBC      = SRCB_IMM;
            resultSrcC = RES_ALURESULT;
            pcUpdateC  = 1'b1;
            nextState  = S_LINK;
         end
         S_LINK: begin
            srcAC     = SRCA_OLDPC;
            srcBC     = SRCB_FOUR;
            nextState = S_ALUWB;
         end
         S_TRAP:  nextState = S_TRAP;
         default: nextState = S_FETCH;
      endcase
   end

   // Outputs are forced low while resetn is held, independent of the clock.
   assign mem_req       = resetn & memReqC;
   assign mem_write     = resetn & memWriteC;
   assign adr_src       = resetn & adrSrcC;
   assign ir_write      = resetn & irWriteC;
   assign pc_write      = resetn & (pcUpdateC | (branchC & cond));
   assign reg_write     = resetn & regWriteC;
   assign result_src    = resetn ? resultSrcC : '0;
   assign alu_src_a     = resetn ? srcAC : '0;
   assign alu_src_b     = resetn ? srcBC : '0;
   assign alu_op        = resetn ? aluOpC : '0;
   assign illegal_instr = illegalSticky;
   assign state_dbg     = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-instruction expected output sequences built from the
// state-by-state behaviour table, plus literal latency / reset / trap checks.
module tb_multicycle_control_fsm;
   import ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       resetn, cond, mem_ready;
   logic [6:0] op;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic       illegal_instr;
   logic [3:0] state_dbg;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.RESET_STATE(S_FETCH), .TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .resetn(resetn), .op(op), .cond(cond), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite;
      logic [1:0] res, srcA, srcB, alu;
      logic       ill;
   } expT;

   typedef struct packed {
      expT  e;
      logic rdy;
   } stepT;

   stepT        plan[$];
   expT         expQ[$];
   expT         actVec, ce;
   stateT       ceName;
   int unsigned nChecks = 0, nPass = 0, cyc = 0;

   assign actVec = {state_dbg, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_op, illegal_instr};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic expT row(input stateT s, input int mr, input int mw, input int adr,
                               input int irw, input int pcw, input int rw, input int res,
                               input int a, input int b, input int alu, input int ill);
      expT r;
      r.st = s;          r.memReq = 1'(mr);   r.memWrite = 1'(mw); r.adrSrc = 1'(adr);
      r.irWrite = 1'(irw); r.pcWrite = 1'(pcw); r.regWrite = 1'(rw);
      r.res = 2'(res);   r.srcA = 2'(a);      r.srcB = 2'(b);      r.alu = 2'(alu);
      r.ill = 1'(ill);
      return r;
   endfunction

   task automatic addStep(input expT e, input logic r);
      stepT s;
      s.e = e;
      s.rdy = r;
      plan.push_back(s);
   endtask

   // Cycles where mem_ready is irrelevant get a random value.
   task automatic addPlain(input expT e);
      addStep(e, 1'($urandom_range(0, 1)));
   endtask

   task automatic addStall(input expT e, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) addStep(e, 1'b0);
      addStep(e, 1'b1);
   endtask

   task automatic buildSeq(input logic [6:0] o, input logic c,
                           input int unsigned fStall, input int unsigned mStall);
      expT aluWb;
      aluWb = row(S_ALUWB, 0,0,0,0,0,1, 0,0,0,0, 0);
      for (int unsigned i = 0; i < fStall; i++)
         addStep(row(S_FETCH, 1,0,0,0,0,0, 2,0,2,0, 0), 1'b0);
      addStep(row(S_FETCH, 1,0,0,1,1,0, 2,0,2,0, 0), 1'b1);
      addPlain(row(S_DECODE, 0,0,0,0,0,0, 0,1,1,0, 0));
      case (o)
         7'b0000011: begin
            addPlain(row(S_MEMADR, 0,0,0,0,0,0, 0,2,1,0, 0));
            addStall(row(S_MEMREAD, 1,0,1,0,0,0, 0,0,0,0, 0), mStall);
            addPlain(row(S_MEMWB, 0,0,0,0,0,1, 1,0,0,0, 0));
         end
         7'b0100011: begin
            addPlain(row(S_MEMADR, 0,0,0,0,0,0, 0,2,1,0, 0));
            addStall(row(S_MEMWRITE, 1,1,1,0,0,0, 0,0,0,0, 0), mStall);
         end
         7'b0110011: begin
            addPlain(row(S_EXECR, 0,0,0,0,0,0, 0,2,0,2, 0));
            addPlain(aluWb);
         end
         7'b0010011: begin
            addPlain(row(S_EXECI, 0,0,0,0,0,0, 0,2,1,2, 0));
            addPlain(aluWb);
         end
         7'b1100011: addPlain(row(S_BRANCH, 0,0,0,0,int'(c),0, 0,2,0,1, 0));
         7'b1101111: begin
            addPlain(row(S_JAL, 0,0,0,0,1,0, 0,1,2,0, 0));
            addPlain(aluWb);
         end
         7'b1100111: begin
            addPlain(row(S_JALR, 0,0,0,0,1,0, 2,2,1,0, 0));
            addPlain(row(S_LINK, 0,0,0,0,0,0, 0,1,2,0, 0));
            addPlain(aluWb);
         end
         7'b0110111, 7'b0010111: begin
            addPlain(row(S_UPPER, 0,0,0,0,0,0, 0,(o == 7'b0110111) ? 3 : 1,1,0, 0));
            addPlain(aluWb);
         end
         default:
            for (int unsigned i = 0; i < 20; i++)
               addPlain(row(S_TRAP, 0,0,0,0,0,0, 0,0,0,0, 1));
      endcase
   endtask

   // Called at posedge+1 with the DUT in FETCH.
   task automatic runPlan(input logic [6:0] o, input logic c);
      stepT s;
      op = o;
      cond = c;
      while (plan.size() != 0) begin
         s = plan.pop_front();
         mem_ready = s.rdy;
         expQ.push_back(s.e);
         @(posedge clk); #1;
      end
   endtask

   task automatic runInstr(input logic [6:0] o, input logic c,
                           input int unsigned fStall, input int unsigned mStall);
      buildSeq(o, c, fStall, mStall);
      runPlan(o, c);
   endtask

   task automatic measureLat(input string name, input logic [6:0] o, input logic c,
                             input int unsigned stalls, input int unsigned expLat,
                             output int unsigned memRd, output int unsigned wbData);
      int unsigned n = 0, left = stalls;
      bit done = 1'b0;
      memRd = 0;
      wbData = 0;
      op = o;
      cond = c;
      check({name, "_start"}, 32'(state_dbg), 32'(S_FETCH));
      while (!done && n < 50) begin
         mem_ready = (stateT'(state_dbg) == S_MEMREAD && left != 0) ? 1'b0 : 1'b1;
         if (!mem_ready) left--;
         if (mem_req && adr_src) memRd++;
         if (reg_write && result_src == 2'd1) wbData++;
         @(posedge clk); #1;
         n++;
         if (stateT'(state_dbg) == S_FETCH) done = 1'b1;
      end
      check({name, "_latency"}, n, expLat);
   endtask

   always @(negedge clk) begin
      if (expQ.size() != 0) begin
         ce = expQ.pop_front();
         ceName = stateT'(ce.st);
         check($sformatf("outputs_%s_c%0d", ceName.name(), cyc), 32'(actVec), 32'(ce));
      end
      cyc++;
   end

   initial begin
      int unsigned memRd, wbData;
      resetn = 1'b0;
      mem_ready = 1'b1;
      cond = 1'b0;
      op = 7'b0110011;
      @(posedge clk); #1;
      repeat (2) begin
         expQ.push_back('0);
         @(posedge clk); #1;
      end
      resetn = 1'b1;

      runInstr(7'b0110011, 1'b0, 0, 0);
      runInstr(7'b0010011, 1'b0, 1, 0);
      runInstr(7'b0000011, 1'b0, 0, 2);
      runInstr(7'b0100011, 1'b0, 2, 1);
      runInstr(7'b1100011, 1'b0, 0, 0);
      runInstr(7'b1100011, 1'b1, 0, 0);
      runInstr(7'b1101111, 1'b1, 0, 0);
      runInstr(7'b1100111, 1'b0, 1, 0);
      runInstr(7'b0110111, 1'b0, 0, 0);
      runInstr(7'b0010111, 1'b1, 0, 0);

      measureLat("add",  7'b0110011, 1'b0, 0, 4, memRd, wbData);
      measureLat("beq",  7'b1100011, 1'b1, 0, 3, memRd, wbData);
      measureLat("jal",  7'b1101111, 1'b0, 0, 4, memRd, wbData);
      measureLat("jalr", 7'b1100111, 1'b0, 0, 5, memRd, wbData);
      measureLat("sw",   7'b0100011, 1'b0, 0, 4, memRd, wbData);
      measureLat("lui",  7'b0110111, 1'b0, 0, 4, memRd, wbData);
      measureLat("lw_stall", 7'b0000011, 1'b0, 2, 7, memRd, wbData);
      check("lw_memreq_cycles", memRd, 3);
      check("lw_data_writebacks", wbData, 1);

      // Asynchronous reset while a store is stalled in MEMWRITE.
      buildSeq(7'b0100011, 1'b0, 0, 3);
      void'(plan.pop_back());
      runPlan(7'b0100011, 1'b0);
      mem_ready = 1'b0;
      check("stall_state", 32'(state_dbg), 32'(S_MEMWRITE));
      check("stall_mem_write", 32'(mem_write), 1);
      #2 resetn = 1'b0;
      #1;
      check("arst_mem_req", 32'(mem_req), 0);
      check("arst_mem_write", 32'(mem_write), 0);
      check("arst_adr_src", 32'(adr_src), 0);
      check("arst_selects", {26'd0, result_src, alu_src_a, alu_src_b}, 0);
      check("arst_state", 32'(state_dbg), 32'(S_FETCH));
      @(posedge clk); #1;
      resetn = 1'b1;
      #1;
      check("post_rst_state", 32'(state_dbg), 32'(S_FETCH));
      check("post_rst_mem_write", 32'(mem_write), 0);
      check("post_rst_mem_req", 32'(mem_req), 1);
      @(posedge clk); #1;
      check("post_rst_still_fetch", 32'(state_dbg), 32'(S_FETCH));

      runInstr(7'b0110011, 1'b0, 0, 0);
      runInstr(7'b1111111, 1'b0, 0, 0);
      check("trap_flag", 32'(illegal_instr), 1);
      check("trap_state", 32'(state_dbg), 32'(S_TRAP));
      resetn = 1'b0;
      #1;
      check("trap_cleared_by_reset", 32'(illegal_instr), 0);
      check("trap_reset_state", 32'(state_dbg), 32'(S_FETCH));
      #20;

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
